// File: rtl/binary_tree_split_ctrl_if.sv
// Request/valve bus of the binary splitter-tree dispenser.
// Optional abort port pair exists only when BINARY_TREE_SPLIT_ABORT_EN is defined.
interface binary_tree_split_ctrl_if #(
  parameter int DEPTH = 4,
  parameter int VOL_W = 16
);
  localparam int NODES = (1 << DEPTH) - 1;

  logic             req_valid;
  logic             req_ready;
  logic [DEPTH-1:0] req_outlet;
  logic [VOL_W-1:0] req_volume;
  logic [NODES-1:0] valve_a;
  logic [NODES-1:0] valve_b;
  logic             src_en;
  logic             busy;
  logic             done;
`ifdef BINARY_TREE_SPLIT_ABORT_EN
  logic             abort;
  logic             aborted;
`endif

  // Requester side
  modport master (
    output req_valid, req_outlet, req_volume,
`ifdef BINARY_TREE_SPLIT_ABORT_EN
    output abort,
    input  aborted,
`endif
    input  req_ready, valve_a, valve_b, src_en, busy, done
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_outlet, req_volume,
`ifdef BINARY_TREE_SPLIT_ABORT_EN
    input  abort,
    output aborted,
`endif
    output req_ready, valve_a, valve_b, src_en, busy, done
  );
endinterface

// File: rtl/binary_tree_split_ctrl.sv
// Binary splitter-tree dispense sequencer: routes one source to one of 2^DEPTH
// outlets, settles, pumps for 'volume' cycles, settles again, then pulses done.
// Optional abort support is enabled with BINARY_TREE_SPLIT_ABORT_EN.
module binary_tree_split_ctrl #(
  parameter int DEPTH  = 4,
  parameter int VOL_W  = 16,
  parameter int SETTLE = 2
) (
  input logic                      clk,
  input logic                      rst_n,
  binary_tree_split_ctrl_if.slave  bus
);
  localparam int NODES = (1 << DEPTH) - 1;
  localparam int CNT_W = (VOL_W > 8) ? VOL_W : 8;
  localparam int NW    = DEPTH + 1;
  localparam int WIDE  = 1 << NW;
  localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ROUTE    = 3'd1,
    S_DISPENSE = 3'd2,
    S_CLOSE    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  // Walk the heap from the root; returns {valve_b, valve_a}. Scratch vectors are
  // 2^(DEPTH+1) wide so the child index never runs past the vector.
  function automatic logic [2*NODES-1:0] path_decode(input logic [DEPTH-1:0] outlet);
    logic [WIDE-1:0]  a_v;
    logic [WIDE-1:0]  b_v;
    logic [NW-1:0]    node;
    logic [DEPTH-1:0] o;
    a_v  = '0;
    b_v  = '0;
    node = '0;
    o    = outlet;
    for (int k = 0; k < DEPTH; k++) begin
      if (o[DEPTH-1] == 1'b0) begin
        a_v[node] = 1'b1;
        node      = {node[NW-2:0], 1'b0} + NW'(1);
      end else begin
        b_v[node] = 1'b1;
        node      = {node[NW-2:0], 1'b0} + NW'(2);
      end
      o = o << 1;
    end
    return {b_v[NODES-1:0], a_v[NODES-1:0]};
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0] outlet_q, outlet_d;
  logic [VOL_W-1:0] volume_q, volume_d;
  logic [NODES-1:0] valve_a_q, valve_a_d;
  logic [NODES-1:0] valve_b_q, valve_b_d;
  logic             src_en_q, src_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic [2*NODES-1:0] path_s;
  logic             accept_s;
  logic             abort_s;
  logic             open_s;

  assign accept_s = bus.req_valid && ready_q;

`ifdef BINARY_TREE_SPLIT_ABORT_EN
  logic abrt_q, abrt_d;
  logic aborted_q, aborted_d;

  assign abort_s     = bus.abort;
  assign bus.aborted = aborted_q;

  // Remember that the current request was cut short, and flag it on its done cycle.
  always_comb begin
    abrt_d = abrt_q;
    if (accept_s) begin
      abrt_d = 1'b0;
    end else if (abort_s && ((state_q == S_ROUTE) || (state_q == S_DISPENSE))) begin
      abrt_d = 1'b1;
    end else begin
      abrt_d = abrt_q;
    end
    aborted_d = (state_d == S_DONE) && abrt_d;
  end

  // Abort bookkeeping registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      abrt_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      abrt_q    <= abrt_d;
      aborted_q <= aborted_d;
    end
  end
`else
  assign abort_s = 1'b0;
`endif

  // Next-state, counter and captured-request logic; outputs derive from state_d
  // so the registered outputs line up with the state they belong to.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    outlet_d = outlet_q;
    volume_d = volume_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d  = S_ROUTE;
          cnt_d    = SETTLE_M1;
          outlet_d = bus.req_outlet;
          volume_d = bus.req_volume;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ROUTE: begin
        if (abort_s) begin
          state_d = S_CLOSE;
          cnt_d   = SETTLE_M1;
        end else if (cnt_q == '0) begin
          if (volume_q == '0) begin
            state_d = S_CLOSE;
            cnt_d   = SETTLE_M1;
          end else begin
            state_d = S_DISPENSE;
            cnt_d   = CNT_W'(volume_q) - CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DISPENSE: begin
        if (abort_s || (cnt_q == '0)) begin
          state_d = S_CLOSE;
          cnt_d   = SETTLE_M1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_CLOSE: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    path_s    = path_decode(outlet_d);
    open_s    = (state_d == S_ROUTE) || (state_d == S_DISPENSE) || (state_d == S_CLOSE);
    valve_a_d = open_s ? path_s[NODES-1:0]       : '0;
    valve_b_d = open_s ? path_s[2*NODES-1:NODES] : '0;
    src_en_d  = (state_d == S_DISPENSE);
    done_d    = (state_d == S_DONE);
    busy_d    = (state_d != S_IDLE);
    ready_d   = (state_d == S_IDLE);
  end

  // State, counter, captured request and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      outlet_q  <= '0;
      volume_q  <= '0;
      valve_a_q <= '0;
      valve_b_q <= '0;
      src_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      outlet_q  <= outlet_d;
      volume_q  <= volume_d;
      valve_a_q <= valve_a_d;
      valve_b_q <= valve_b_d;
      src_en_q  <= src_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.valve_a   = valve_a_q;
  assign bus.valve_b   = valve_b_q;
  assign bus.src_en    = src_en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_binary_tree_split_ctrl.sv
// Directed bench for binary_tree_split_ctrl (DEPTH=4, VOL_W=16, SETTLE=2).
// Covers the abort path when BINARY_TREE_SPLIT_ABORT_EN is defined.
module tb_binary_tree_split_ctrl;
  localparam int DEPTH  = 4;
  localparam int VOL_W  = 16;
  localparam int SETTLE = 2;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   done_cnt;

  binary_tree_split_ctrl_if #(.DEPTH(DEPTH), .VOL_W(VOL_W)) bus ();

  binary_tree_split_ctrl #(.DEPTH(DEPTH), .VOL_W(VOL_W), .SETTLE(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request at the current negedge and check every cycle until ready returns.
  task automatic run_req(input logic [3:0] outlet, input logic [15:0] vol,
                         input logic [31:0] exp_a, input logic [31:0] exp_b, input bit hold);
    int len;
    len = 2 * SETTLE + int'(vol);
    bus.req_outlet = outlet;
    bus.req_volume = vol;
    bus.req_valid  = 1'b1;
    check("pre_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    for (int n = 1; n <= len + 2; n++) begin
      @(negedge clk);
      check($sformatf("valve_a o%0d c%0d", outlet, n), {17'd0, bus.valve_a}, (n <= len) ? exp_a : 32'd0);
      check($sformatf("valve_b o%0d c%0d", outlet, n), {17'd0, bus.valve_b}, (n <= len) ? exp_b : 32'd0);
      check($sformatf("src_en o%0d c%0d", outlet, n), {31'd0, bus.src_en},
            ((n >= SETTLE + 1) && (n <= SETTLE + int'(vol))) ? 32'd1 : 32'd0);
      check($sformatf("done o%0d c%0d", outlet, n), {31'd0, bus.done}, (n == len + 1) ? 32'd1 : 32'd0);
      check($sformatf("ready o%0d c%0d", outlet, n), {31'd0, bus.req_ready}, (n == len + 2) ? 32'd1 : 32'd0);
      check($sformatf("busy o%0d c%0d", outlet, n), {31'd0, bus.busy}, (n <= len + 1) ? 32'd1 : 32'd0);
`ifdef BINARY_TREE_SPLIT_ABORT_EN
      check($sformatf("aborted o%0d c%0d", outlet, n), {31'd0, bus.aborted}, 32'd0);
`endif
      if (hold) begin
        bus.req_outlet = ~outlet;
        bus.req_volume = vol + 16'(n);
      end else begin
        bus.req_valid = 1'b0;
      end
    end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    done_cnt       = 0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_outlet = 4'd0;
    bus.req_volume = 16'd0;
`ifdef BINARY_TREE_SPLIT_ABORT_EN
    bus.abort      = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valve_a", {17'd0, bus.valve_a}, 32'd0);
    check("rst_valve_b", {17'd0, bus.valve_b}, 32'd0);
    check("rst_src_en", {31'd0, bus.src_en}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic paths, including all-ones / all-zeros outlets and zero volume
    run_req(4'd5,  16'd3, 32'h0011, 32'h0202, 1'b0);
    run_req(4'd15, 16'd1, 32'h0000, 32'h4045, 1'b0);
    run_req(4'd0,  16'd1, 32'h008B, 32'h0000, 1'b0);
    run_req(4'd9,  16'd0, 32'h0024, 32'h0801, 1'b0);

    // req_valid held high with fields changing every cycle
    run_req(4'd5,  16'd1, 32'h0011, 32'h0202, 1'b1);
    run_req(4'd9,  16'd2, 32'h0024, 32'h0801, 1'b1);
    run_req(4'd15, 16'd1, 32'h0000, 32'h4045, 1'b1);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("idle_after_hold", {31'd0, bus.busy}, 32'd0);

    // Reset in the middle of a long dispense
    bus.req_outlet = 4'd3;
    bus.req_volume = 16'd100;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_src_en", {31'd0, bus.src_en}, 32'd1);
    check("mid_valve_a", {17'd0, bus.valve_a}, 32'h0003);
    check("mid_valve_b", {17'd0, bus.valve_b}, 32'h0108);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("mr_valve_a", {17'd0, bus.valve_a}, 32'd0);
    check("mr_valve_b", {17'd0, bus.valve_b}, 32'd0);
    check("mr_src_en", {31'd0, bus.src_en}, 32'd0);
    check("mr_ready", {31'd0, bus.req_ready}, 32'd1);
    check("mr_busy", {31'd0, bus.busy}, 32'd0);
    check("mr_done", {31'd0, bus.done}, 32'd0);
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_cnt++;
    end
    check("mr_no_done", done_cnt, 32'd0);
    check("mr_still_idle", {31'd0, bus.busy}, 32'd0);

`ifdef BINARY_TREE_SPLIT_ABORT_EN
    // Abort on the second pump cycle of a 50-cycle dispense
    bus.req_outlet = 4'd5;
    bus.req_volume = 16'd50;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      check($sformatf("ab_valve_a c%0d", n), {17'd0, bus.valve_a}, (n <= 6) ? 32'h0011 : 32'd0);
      check($sformatf("ab_valve_b c%0d", n), {17'd0, bus.valve_b}, (n <= 6) ? 32'h0202 : 32'd0);
      check($sformatf("ab_src_en c%0d", n), {31'd0, bus.src_en}, ((n == 3) || (n == 4)) ? 32'd1 : 32'd0);
      check($sformatf("ab_done c%0d", n), {31'd0, bus.done}, (n == 7) ? 32'd1 : 32'd0);
      check($sformatf("ab_aborted c%0d", n), {31'd0, bus.aborted}, (n == 7) ? 32'd1 : 32'd0);
      check($sformatf("ab_ready c%0d", n), {31'd0, bus.req_ready}, (n == 8) ? 32'd1 : 32'd0);
      if (n == 4) bus.abort = 1'b1;
      if (n == 5) bus.abort = 1'b0;
    end
`endif

    // Normal request after reset / abort
    run_req(4'd0, 16'd1, 32'h008B, 32'h0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
